// File: rtl/add_sub_pkg.sv
// Shared constants for the serial adder-subtractor: FSM state encoding and
// operation mode values.
package add_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : add_sub_pkg

// File: rtl/add_sub_slice.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its
// MSB so the top level can derive signed overflow on the final slice.
module add_sub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic carry;

  // NOTE: every output gets a default before the loop so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    carry  = cin_i;
    sum_o  = '0;
    cmsb_o = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb_o = carry;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule : add_sub_slice

// File: rtl/serial_add_sub.sv
// Multi-cycle two's-complement adder-subtractor: one WIDTH-bit operation is
// processed DIGIT bits per clock through a shared slice, with valid/ready on both sides.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  add_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i    (a_q[cnt_q*DIGIT +: DIGIT]),
    .b_i    (b_q[cnt_q*DIGIT +: DIGIT]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B once here, inject the +1 as carry-in.
          a_d     = a;
          b_d     = b ^ {WIDTH{mode}};
          carry_d = (mode == MODE_SUB);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q*DIGIT +: DIGIT] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_out_d = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          zero_d  = (sum_d == '0);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; all registers, operands included, reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule : serial_add_sub
